// File: rtl/cam_pkg.sv
// Shared definitions for the camera frame-capture sequencer.
// State encoding, default frame geometry and address width derivation.
package cam_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SYNC,
        CAPTURE,
        DONE
    } cap_state_t;

    localparam int unsigned CAM_H_ACTIVE = 320;
    localparam int unsigned CAM_V_ACTIVE = 240;

    // Smallest address width covering one full frame of pixels.
    function automatic int unsigned cam_addr_w(
        input int unsigned h,
        input int unsigned v
    );
        return $clog2(h * v);
    endfunction

    localparam int unsigned CAM_ADDR_W =
        cam_addr_w(CAM_H_ACTIVE, CAM_V_ACTIVE);

endpackage

// File: rtl/sync_edge_detect.sv
// One-cycle delay of a level signal plus rise/fall pulses.
// Ports: clk, reset (async high), d in; rise, fall pulses out.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/capture_sequencer.sv
// Frame-capture controller: follows vsync/href, drives the external
// address counter (cnt_en, cnt_rst_n) and the frame-buffer strobe we.
// Ports: clk, reset, start, continuous, abort, vsync, href in;
//        cnt_en, cnt_rst_n, we, busy, frame_done, err_line,
//        err_frame out (all registered).
module capture_sequencer
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE = CAM_H_ACTIVE,
    parameter int unsigned V_ACTIVE = CAM_V_ACTIVE,
    parameter int unsigned ADDR_W   = CAM_ADDR_W
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic continuous,
    input  logic abort,
    input  logic vsync,
    input  logic href,
    output logic cnt_en,
    output logic cnt_rst_n,
    output logic we,
    output logic busy,
    output logic frame_done,
    output logic err_line,
    output logic err_frame
);

    if (ADDR_W < cam_addr_w(H_ACTIVE, V_ACTIVE)) begin : g_addr_chk
        $error("ADDR_W too small for one frame");
    end

    // Counters hold one value past the active size so that
    // overlong lines/frames stay distinguishable from exact ones.
    localparam int PIX_W  = $clog2(H_ACTIVE + 2);
    localparam int LINE_W = $clog2(V_ACTIVE + 2);

    localparam logic [PIX_W-1:0]  PIX_H    = PIX_W'(H_ACTIVE);
    localparam logic [PIX_W-1:0]  PIX_MAX  = PIX_W'(H_ACTIVE + 1);
    localparam logic [LINE_W-1:0] LINE_V   = LINE_W'(V_ACTIVE);
    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(V_ACTIVE + 1);

    logic vs_rise;
    logic vs_fall;
    logic hr_fall;
    logic hr_rise_unused;

    sync_edge_detect u_vsync_edge (
        .clk  (clk),
        .reset(reset),
        .d    (vsync),
        .rise (vs_rise),
        .fall (vs_fall)
    );

    sync_edge_detect u_href_edge (
        .clk  (clk),
        .reset(reset),
        .d    (href),
        .rise (hr_rise_unused),
        .fall (hr_fall)
    );

    cap_state_t        state, state_d;
    logic [PIX_W-1:0]  pix_cnt, pix_d;
    logic [LINE_W-1:0] line_cnt, line_d;
    logic              byte_ph, ph_d;
    logic              wr_d;
    logic              rst_n_d;
    logic              done_d;
    logic              el_d;
    logic              ef_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            byte_ph    <= 1'b0;
            cnt_en     <= 1'b0;
            we         <= 1'b0;
            cnt_rst_n  <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err_line   <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            state      <= state_d;
            pix_cnt    <= pix_d;
            line_cnt   <= line_d;
            byte_ph    <= ph_d;
            cnt_en     <= wr_d;
            we         <= wr_d;
            cnt_rst_n  <= rst_n_d;
            busy       <= (state_d != IDLE);
            frame_done <= done_d;
            err_line   <= el_d;
            err_frame  <= ef_d;
        end
    end

    always_comb begin
        state_d = state;
        pix_d   = pix_cnt;
        line_d  = line_cnt;
        ph_d    = byte_ph;
        wr_d    = 1'b0;
        rst_n_d = 1'b1;
        done_d  = 1'b0;
        el_d    = err_line;
        ef_d    = err_frame;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = ARM;
                    el_d    = 1'b0;
                    ef_d    = 1'b0;
                end
            end
            ARM: begin
                if (vsync) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (vs_fall) begin
                    state_d = CAPTURE;
                    rst_n_d = 1'b0;
                    pix_d   = '0;
                    line_d  = '0;
                    ph_d    = 1'b0;
                end
            end
            CAPTURE: begin
                if (href) begin
                    ph_d = ~byte_ph;
                    if (byte_ph) begin
                        wr_d = (pix_cnt < PIX_H) &&
                               (line_cnt < LINE_V);
                        if (pix_cnt != PIX_MAX) begin
                            pix_d = pix_cnt + 1'b1;
                        end
                    end
                end
                if (hr_fall) begin
                    if ((pix_cnt != PIX_H) || byte_ph) begin
                        el_d = 1'b1;
                    end
                    if (line_cnt != LINE_MAX) begin
                        line_d = line_cnt + 1'b1;
                    end
                    pix_d = '0;
                    ph_d  = 1'b0;
                end
                // line_d already includes a same-cycle href fall.
                if (vs_rise) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    wr_d    = 1'b0;
                    if (line_d != LINE_V) begin
                        ef_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = continuous ? SYNC : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d = IDLE;
            wr_d    = 1'b0;
            done_d  = 1'b0;
            rst_n_d = 1'b1;
            el_d    = err_line;
            ef_d    = err_frame;
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomized scoreboard bench for capture_sequencer (H=4, V=3).
// Frame expectations come from a line-length model of each frame.
module tb_capture_sequencer;

    localparam int H = 4;
    localparam int V = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic continuous = 1'b0;
    logic abort = 1'b0;
    logic vsync = 1'b0;
    logic href = 1'b0;
    logic cnt_en;
    logic cnt_rst_n;
    logic we;
    logic busy;
    logic frame_done;
    logic err_line;
    logic err_frame;

    capture_sequencer #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .ADDR_W  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .continuous(continuous),
        .abort     (abort),
        .vsync     (vsync),
        .href      (href),
        .cnt_en    (cnt_en),
        .cnt_rst_n (cnt_rst_n),
        .we        (we),
        .busy      (busy),
        .frame_done(frame_done),
        .err_line  (err_line),
        .err_frame (err_frame)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int wr;
        int el;
        int ef;
        int fwe;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int passes = 0;
    int exp_el = 0;
    int exp_ef = 0;

    task automatic check(input string name, input int act,
                         input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d required %0d",
                      name, act, req);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int m_wr = 0;
    int m_rst = 0;
    int m_fwe = -1;
    bit m_seen_rst = 0;

    always @(negedge clk) begin
        if (reset) begin
            m_wr = 0; m_rst = 0; m_fwe = -1; m_seen_rst = 0;
        end else begin
            if (we || cnt_en) begin
                check("we_cnt_en_rule",
                      int'(we == cnt_en && cnt_rst_n && busy), 1);
            end
            if (!cnt_rst_n) begin
                m_rst++; m_wr = 0; m_fwe = -1; m_seen_rst = 1;
            end
            if (we) begin
                check("we_after_clear", int'(m_seen_rst), 1);
                m_wr++;
                if (m_fwe < 0) m_fwe = cyc;
            end
            if (frame_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("frame_we_count", m_wr, e.wr);
                    check("frame_err_line", int'(err_line), e.el);
                    check("frame_err_frame", int'(err_frame), e.ef);
                    check("first_we_cycle", m_fwe, e.fwe);
                    check("cnt_clear_pulses", m_rst, 1);
                end
                m_rst = 0; m_seen_rst = 0;
            end
            if (!busy) begin
                m_wr = 0; m_rst = 0; m_fwe = -1; m_seen_rst = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic blank(input int n);
        vsync = 1'b1;
        href  = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_start();
        exp_el = 0;
        exp_ef = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic drive_line(input int nb);
        for (int b = 0; b < nb; b++) begin
            href = 1'b1;
            step();
        end
        href = 1'b0;
    endtask

    // Drives one frame from blank to the next vsync rise; when capt
    // is set the model's expectation for it is queued first.
    task automatic drive_frame(input int nl, input int lens[8],
                               input bit capt, input bit gap0);
        exp_t e;
        e.fwe = -1;
        vsync = 1'b0;
        href  = 1'b0;
        step();
        step();
        for (int i = 0; i < nl; i++) begin
            for (int b = 0; b < lens[i]; b++) begin
                href = 1'b1;
                if (i == 0 && b == 1) e.fwe = cyc + 1;
                step();
            end
            if (i < nl - 1) begin
                href = 1'b0;
                step();
                step();
            end
        end
        if (capt) begin
            e.wr = 0;
            for (int i = 0; i < nl; i++) begin
                int px;
                px = lens[i] / 2;
                if (i < V) e.wr += (px < H) ? px : H;
                if (lens[i] != 2 * H) exp_el = 1;
            end
            if (nl != V) exp_ef = 1;
            e.el = exp_el;
            e.ef = exp_ef;
            exp_q.push_back(e);
        end
        href = 1'b0;
        if (!gap0) step();
        vsync = 1'b1;
        step();
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 40) begin
            step();
            n++;
        end
        check({name, "_sb_drain"}, exp_q.size(), 0);
        check({name, "_idle"}, int'(busy), 0);
    endtask

    function automatic int outs();
        return int'({busy, we, cnt_en, cnt_rst_n,
                     frame_done, err_line, err_frame});
    endfunction

    int lens[8];
    int tbl[8] = '{8, 8, 8, 8, 6, 7, 10, 12};
    int ntbl[4] = '{3, 3, 2, 4};

    initial begin
        repeat (3) step();
        check("reset_held_outputs", outs(), 8);
        reset = 1'b0;
        step();
        check("after_reset_outputs", outs(), 8);

        // clean single-shot frame
        lens = '{8, 8, 8, 0, 0, 0, 0, 0};
        blank(2); do_start(); blank(3);
        drive_frame(3, lens, 1, 0);
        blank(4);
        wait_done("clean");

        // start while a frame is already running
        vsync = 1'b0;
        drive_line(8); step();
        do_start();
        drive_line(8); step();
        blank(6);
        lens = '{8, 8, 8, 0, 0, 0, 0, 0};
        drive_frame(3, lens, 1, 0);
        blank(4);
        wait_done("midframe_start");

        // 10-byte line
        lens = '{8, 10, 8, 0, 0, 0, 0, 0};
        blank(2); do_start(); blank(3);
        drive_frame(3, lens, 1, 0);
        blank(4);
        wait_done("long_line");

        // short frame
        lens = '{8, 8, 0, 0, 0, 0, 0, 0};
        blank(2); do_start(); blank(3);
        drive_frame(2, lens, 1, 1);
        blank(4);
        wait_done("short_frame");

        // continuous over two frames
        lens = '{8, 8, 8, 0, 0, 0, 0, 0};
        continuous = 1'b1;
        blank(2); do_start(); blank(3);
        drive_frame(3, lens, 1, 0);
        blank(5);
        check("cont_busy", int'(busy), 1);
        continuous = 1'b0;
        drive_frame(3, lens, 1, 0);
        blank(4);
        wait_done("continuous");

        // randomized runs
        for (int r = 0; r < 12; r++) begin
            int nf;
            nf = $urandom_range(1, 3);
            continuous = (nf > 1);
            blank(2); do_start(); blank(3);
            for (int f = 0; f < nf; f++) begin
                int nl;
                if (f == nf - 1) continuous = 1'b0;
                nl = ntbl[$urandom_range(0, 3)];
                for (int i = 0; i < 8; i++)
                    lens[i] = tbl[$urandom_range(0, 7)];
                drive_frame(nl, lens, 1,
                            ($urandom_range(0, 3) == 0));
                blank(5);
                if (f < nf - 1)
                    check("rand_cont_busy", int'(busy), 1);
            end
            wait_done("random");
        end

        // abort mid-line
        blank(2); do_start(); blank(3);
        vsync = 1'b0; step(); step();
        drive_line(10); step(); step();
        href = 1'b1; step();
        href = 1'b1; step();
        href = 1'b1; abort = 1'b1; step();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_we", int'(we | cnt_en), 0);
        check("abort_err_kept", int'(err_line), 1);
        drive_line(3); step(); step();
        drive_line(8); step();
        blank(6);
        check("abort_stays_idle", int'(busy), 0);

        // async reset mid-capture
        blank(2); do_start(); blank(3);
        vsync = 1'b0; step(); step();
        drive_line(6); step(); step();
        href = 1'b1; step();
        href = 1'b1; step();
        href = 1'b1; step();
        check("pre_reset_err_line", int'(err_line), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset_outputs", outs(), 8);
        step();
        reset = 1'b0;
        href = 1'b0;
        blank(4);
        check("post_reset_outputs", outs(), 8);
        check("final_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Frame-capture controller for the camera front end.
- Watches the camera sync signals (vsync, href, byte stream) and drives enable and clear for the frame-buffer address Counter (n = ADDR_W, active-low async clear).
- Generates the frame-buffer write strobe and reports frame completion and geometry errors.
- Sits between the camera input registers and the frame-buffer write port, in the pixel clock domain.

Parameters:
- H_ACTIVE, 320, pixels per line (one pixel = 2 bytes).
- V_ACTIVE, 240, lines per frame.
- ADDR_W, 17, width of the external address Counter; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
- clk  in  1  pixel clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  capture request, sampled in IDLE only.
- continuous  in  1  1 = re-arm after each frame; 0 = single snapshot.
- abort  in  1  synchronous stop; highest priority after reset.
- vsync  in  1  camera vsync; high = vertical blank.
- href  in  1  camera href; high = active bytes on this clk.
- cnt_en  out  1  address Counter enable.
- cnt_rst_n  out  1  address Counter clear, active-low, registered.
- we  out  1  frame-buffer write strobe.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- err_line  out  1  sticky: some line's pixel count != H_ACTIVE.
- err_frame  out  1  sticky: captured line count != V_ACTIVE.

Behaviour:
- Reset values: state IDLE, cnt_en=0, cnt_rst_n=1, we=0, busy=0, frame_done=0, err_*=0, all internal counters 0.
- All outputs are registered.
- Edge detection: vsync_q and href_q are delayed by one clk.
  - vsync fall = !vsync & vsync_q; vsync rise = vsync & !vsync_q; href fall = !href & href_q.
- IDLE:
  - start=1 goes to ARM.
  - err_line and err_frame clear on this transition.
- ARM:
  - Wait for vsync=1, then go to SYNC.
  - Guarantees capture never begins mid-frame.
- SYNC:
  - On vsync fall, go to CAPTURE.
  - cnt_rst_n=0 for exactly the one cycle after detection.
  - line_cnt, pix_cnt and byte_ph reset to 0.
- CAPTURE, while href=1:
  - byte_ph toggles every clk.
  - On the cycle with byte_ph=1 (second byte), pixel completes.
  - If pix_cnt < H_ACTIVE and line_cnt < V_ACTIVE: we=1 and cnt_en=1 on the following cycle (latency 1), so data is written at the current address and the counter then increments.
  - pix_cnt saturates at H_ACTIVE+1.
  - Excess pixels and lines are dropped: no we, no cnt_en, so the frame buffer is never overrun.
- CAPTURE, on href fall:
  - If pix_cnt != H_ACTIVE or byte_ph=1 (odd byte count), set err_line.
  - Increment line_cnt (saturates at V_ACTIVE+1).
  - Clear pix_cnt and byte_ph.
- CAPTURE, on vsync rise:
  - Go to DONE.
  - If line_cnt != V_ACTIVE, set err_frame.
  - An href fall in the same cycle is processed first (counts the line).
- DONE:
  - frame_done=1 for one cycle.
  - continuous=1: go to SYNC (errors not cleared).
  - continuous=0: go to IDLE.
- abort=1 in any state:
  - Go to IDLE next cycle; cnt_en=0, we=0, no frame_done.
  - err_* keep their values.
- start is ignored outside IDLE.
- start and abort together in IDLE: abort wins, stay in IDLE.
- cnt_en and we are always equal; they are never high outside CAPTURE or in the cycle cnt_rst_n=0.
- Asserting reset mid-frame returns to IDLE immediately (async). Outputs go to reset values before the next edge.

Decomposition:
- Shared package cam_pkg:
  - state encoding enum (IDLE, ARM, SYNC, CAPTURE, DONE);
  - default H_ACTIVE / V_ACTIVE constants;
  - ADDR_W derivation constant.
- One natural sub-module, sync_edge_detect: registers a signal and outputs rise/fall pulses; instantiated for vsync and href.
- The address Counter stays external, driven by cnt_en and cnt_rst_n.

Test Plan:
- H_ACTIVE=4, V_ACTIVE=3, single shot, clean frame (3 lines × 8 bytes) -> exactly 12 we pulses; one cnt_rst_n low pulse before the first; frame_done once; err_*=0; return to IDLE.
- start asserted mid-frame (vsync=0) -> no we until vsync goes high then low; first we appears 1 cycle after the second byte of the next frame's first pixel.
- Line with 10 bytes (5 pixels) -> only 4 we for that line; err_line=1 sticky; total we=12.
- Frame with 2 lines then vsync rise -> 8 we; err_frame=1; frame_done pulses.
- continuous=1 over two frames -> two frame_done pulses, two cnt_rst_n pulses, busy stays 1, 24 we total.
- abort in mid-line, then reset asserted mid-CAPTURE -> abort: IDLE next cycle, we=0, no frame_done. Reset: all outputs at reset values immediately.
